fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core. It holds the program counter and drives the byte-addressed, big-endian, combinational-read instruction memory. It captures the returned 32-bit word into the IF/ID pipeline register for the decode stage. It also supports stall (hazard unit), flush, and PC redirect on taken branch/jump.

---
 rtl/core_pkg.sv | 26 ++
 rtl/if_id_register.sv | 49 ++++
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: architectural constants, the IF/ID pipeline
// register layout and small address helpers used by the fetch stage.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            misalign;
    } if_id_t;

    // Instructions are word sized, so redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: reset > flush > stall > capture.
// Flush injects a bubble but keeps the PC fields of the squashed slot.
module if_id_register
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_r;
    if_id_t next_s;

    // Next IF/ID contents for the non-reset cases.
    always_comb begin
        next_s = q_r;
        if (flush) begin
            next_s.instr    = NOP_INSTR;
            next_s.valid    = 1'b0;
            next_s.misalign = 1'b0;
        end else if (stall) begin
            next_s = q_r;
        end else begin
            next_s = d;
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r.instr    <= NOP_INSTR;
            q_r.pc       <= RESET_PC;
            q_r.pc_plus4 <= RESET_PC + 32'd4;
            q_r.valid    <= 1'b0;
            q_r.misalign <= 1'b0;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, next-PC selection and the
// instruction memory address, feeding the IF/ID pipeline register.
module fetch_stage
    import core_pkg::*;
#(
    parameter int              N         = 7,
    parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [N-1:0]    imem_addr,
    input  logic [XLEN-1:0] imem_rd,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            misalign_d
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic            fetch_misalign_r;
    logic            fetch_misalign_next_s;
    if_id_t          if_id_d_s;
    if_id_t          if_id_q_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // Next-PC selection: redirect beats stall; the misalign flag follows the
    // PC it describes and drops as soon as the PC advances sequentially.
    always_comb begin
        pc_next_s             = pc_r;
        fetch_misalign_next_s = fetch_misalign_r;
        if (pc_src) begin
            pc_next_s             = word_align(pc_target);
            fetch_misalign_next_s = is_misaligned(pc_target);
        end else if (stall_f) begin
            pc_next_s             = pc_r;
            fetch_misalign_next_s = fetch_misalign_r;
        end else begin
            pc_next_s             = pc_plus4_s;
            fetch_misalign_next_s = 1'b0;
        end
    end

    // PC and misalign flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r             <= RESET_PC;
            fetch_misalign_r <= 1'b0;
        end else begin
            pc_r             <= pc_next_s;
            fetch_misalign_r <= fetch_misalign_next_s;
        end
    end

    // Fetch packet presented to IF/ID for capture.
    always_comb begin
        if_id_d_s.instr    = imem_rd;
        if_id_d_s.pc       = pc_r;
        if_id_d_s.pc_plus4 = pc_plus4_s;
        if_id_d_s.valid    = 1'b1;
        if_id_d_s.misalign = fetch_misalign_r;
    end

    if_id_register #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_d),
        .stall (stall_d),
        .d     (if_id_d_s),
        .q     (if_id_q_s)
    );

    // Upper PC bits are dropped so fetch wraps within the memory.
    assign imem_addr  = pc_r[N-1:0];
    assign pc_f       = pc_r;
    assign instr_d    = if_id_q_s.instr;
    assign pc_d       = if_id_q_s.pc;
    assign pc_plus4_d = if_id_q_s.pc_plus4;
    assign valid_d    = if_id_q_s.valid;
    assign misalign_d = if_id_q_s.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// control traffic, checked against a behavioural model of the pipeline.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, stall_f, stall_d, flush_d, pc_src;
    logic [31:0] pc_target;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, misalign_d;

    logic [7:0]  mem [0:127];

    int compared   = 0;
    int mismatched = 0;

    // Reference state: fetch PC, pending misalign, and the decode slot.
    logic [31:0] m_pc, m_instr, m_pcd, m_p4;
    logic        m_mis, m_valid, m_misd;

    always #5 clk = ~clk;

    // Byte-addressed big-endian memory with combinational read.
    assign imem_rd = {mem[imem_addr], mem[imem_addr + 7'd1],
                      mem[imem_addr + 7'd2], mem[imem_addr + 7'd3]};

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d),
        .misalign_d (misalign_d)
    );

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        int a;
        a = addr % 128;
        return {mem[a], mem[(a + 1) % 128], mem[(a + 2) % 128], mem[(a + 3) % 128]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("pc_f",       pc_f,                  m_pc);
        check("imem_addr",  {25'd0, imem_addr},    m_pc % 128);
        check("instr_d",    instr_d,               m_instr);
        check("pc_d",       pc_d,                  m_pcd);
        check("pc_plus4_d", pc_plus4_d,            m_p4);
        check("valid_d",    {31'd0, valid_d},      {31'd0, m_valid});
        check("misalign_d", {31'd0, misalign_d},   {31'd0, m_misd});
    endtask

    // One clock: drive controls, advance the model by the fetch rules, compare.
    task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                        input logic ps, input logic [31:0] tgt);
        logic [31:0] n_pc, n_instr, n_pcd, n_p4;
        logic        n_mis, n_valid, n_misd;
        rst_n = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src = ps; pc_target = tgt;
        n_pc = m_pc; n_mis = m_mis;
        n_instr = m_instr; n_pcd = m_pcd; n_p4 = m_p4; n_valid = m_valid; n_misd = m_misd;
        if (!r) begin
            n_pc = RPC; n_mis = 1'b0;
            n_instr = NOP; n_pcd = RPC; n_p4 = RPC + 32'd4; n_valid = 1'b0; n_misd = 1'b0;
        end else begin
            if (fl) begin
                n_instr = NOP; n_valid = 1'b0; n_misd = 1'b0;
            end else if (!sd) begin
                n_instr = word_at(m_pc); n_pcd = m_pc; n_p4 = m_pc + 32'd4;
                n_valid = 1'b1; n_misd = m_mis;
            end
            if (ps) begin
                n_pc = tgt - (tgt % 4); n_mis = (tgt % 4) != 0;
            end else if (!sf) begin
                n_pc = m_pc + 32'd4; n_mis = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_mis = n_mis;
        m_instr = n_instr; m_pcd = n_pcd; m_p4 = n_p4; m_valid = n_valid; m_misd = n_misd;
        check_all();
    endtask

    initial begin
        logic [31:0] w1, w2;
        rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src = 1'b0; pc_target = 32'd0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        m_pc = '0; m_mis = 1'b0; m_instr = '0; m_pcd = '0; m_p4 = '0;
        m_valid = 1'b0; m_misd = 1'b0;
        w1 = word_at(32'd4);
        w2 = word_at(32'd8);
        @(negedge clk);

        // Reset then free run from 0.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("reset_pc", pc_f, RPC);
        check("reset_instr", instr_d, NOP);
        check("reset_p4", pc_plus4_d, 32'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("run_pc8", pc_f, 32'd8);
        check("run_w1", instr_d, w1);

        // Full stall at pc 8, then resume.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
            check("stall_pc", pc_f, 32'd8);
            check("stall_instr", instr_d, w1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("resume_w2", instr_d, w2);
        check("resume_pc", pc_f, 32'd12);

        // Taken branch with flush, then capture of the target word.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
        check("br_pc", pc_f, 32'h40);
        check("br_bubble", {31'd0, valid_d}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("br_pcd", pc_d, 32'h40);

        // Redirect beats stall_f; flush beats stall_d.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20);
        check("redir_stall", pc_f, 32'h20);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("flush_stall", instr_d, NOP);

        // Misaligned target is forced to a word and flagged once.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22);
        check("mis_pc", pc_f, 32'h20);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("mis_flag", {31'd0, misalign_d}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("mis_clear", {31'd0, misalign_d}, 32'd0);

        // Address wrap at the top of the memory, then reset mid-redirect.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7C);
        check("wrap_a", {25'd0, imem_addr}, 32'h7C);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap_pc", pc_f, 32'h80);
        check("wrap_b", {25'd0, imem_addr}, 32'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h50);
        check("rst_mid", pc_f, RPC);

        // 32-bit PC wrap.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("pc_wrap32", pc_f, 32'd0);
        check("p4_wrap32", pc_plus4_d, 32'd0);

        // Random control traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, sf, sd, fl, ps;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 49) != 0);
            sd  = ($urandom_range(0, 3) == 0);
            sf  = sd & ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 5) == 0);
            ps  = ($urandom_range(0, 5) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step(r, sf, sd, fl, ps, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
